// File: rtl/axis_channel_extract_packer.sv
// -----------------------------------------------------------------------------
// axis_channel_extract_packer
//
// Takes a pixel-interleaved AXI4-Stream (ch0, ch1, ..., chC-1, ch0, ...) and
// forwards only the items of one channel, packed densely into full-width
// output words. The channel phase is carried across beats, so the number of
// items per beat does not have to be a multiple of the channel count.
//
// Ports:
//   axis_aclk, axis_resetn  clock, asynchronous active-low reset
//   channel_select          channel to extract, latched on the first beat
//                           of each packet
//   s_axis_*                interleaved input stream (tkeep used on tlast only)
//   m_axis_*                packed single-channel output stream
//   stat_item_count         (AXIS_CHANNEL_EXTRACT_STATS_EN) items emitted,
//                           wraps modulo 2^32
//   stat_empty_pkt_count    (AXIS_CHANNEL_EXTRACT_STATS_EN) packets dropped
//                           with no selected items, saturating
//
// Optional feature macro: AXIS_CHANNEL_EXTRACT_STATS_EN
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and payload stable until that edge; ready may change
// freely. s_axis_tready = !m_axis_tvalid || m_axis_tready (forced low in
// reset), so an input beat is only taken when the output register can
// accept whatever that beat produces.
// -----------------------------------------------------------------------------
module axis_channel_extract_packer #(
   parameter  int TDATA_WIDTH        = 256,
   parameter  int ITEM_WIDTH         = 8,
   parameter  int CHANNEL_COUNT      = 3,
   localparam int ITEM_COUNT         = TDATA_WIDTH / ITEM_WIDTH,
   localparam int CHANNEL_COUNT_BITS = $clog2(CHANNEL_COUNT)
) (
   input  logic                          axis_aclk,
   input  logic                          axis_resetn,
   input  logic [CHANNEL_COUNT_BITS-1:0] channel_select,
   input  logic [TDATA_WIDTH-1:0]        s_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0]      s_axis_tkeep,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tlast,
   output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]      m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast
`ifdef AXIS_CHANNEL_EXTRACT_STATS_EN
   ,
   output logic [31:0]                   stat_item_count,
   output logic [15:0]                   stat_empty_pkt_count
`endif
);

   localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
   localparam int ITEM_BYTES = ITEM_WIDTH / 8;
   localparam int FC_BITS    = $clog2(ITEM_COUNT + 1);

   logic [CHANNEL_COUNT_BITS-1:0] phase_q, phase_d;
   logic [CHANNEL_COUNT_BITS-1:0] sel_q, sel_d;
   logic [CHANNEL_COUNT_BITS-1:0] cur_sel, cur_phase;
   logic [FC_BITS-1:0]            fc_q, fc_d;
   logic                          sop_q, sop_d;
   logic                          pe_q, pe_d;
   logic [TDATA_WIDTH-1:0]        acc_q, acc_d, acc_new;
   logic [TDATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic [KEEP_WIDTH-1:0]         out_keep_q, out_keep_d;
   logic                          out_valid_q, out_valid_d;
   logic                          out_last_q, out_last_d;
   logic                          accept;
   logic                          emit_full, emit_partial, emit_empty, drop_empty;
   int                            k_cnt;
   int                            total;

   assign s_axis_tready = axis_resetn && (!out_valid_q || m_axis_tready);
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;

   // Select and compact this beat's items onto the accumulator. The first
   // beat of a packet uses the live channel_select and phase 0.
   always_comb begin
      cur_sel   = sop_q ? channel_select : sel_q;
      cur_phase = sop_q ? '0 : phase_q;
      acc_new   = acc_q;
      k_cnt     = 0;
      for (int i = 0; i < ITEM_COUNT; i++) begin
         if ((((int'(cur_phase) + i) % CHANNEL_COUNT) == int'(cur_sel)) &&
             (!s_axis_tlast || (&s_axis_tkeep[i*ITEM_BYTES +: ITEM_BYTES]))) begin
            // fc + k never exceeds N; the guard only keeps the index in range.
            if (int'(fc_q) + k_cnt < ITEM_COUNT) begin
               acc_new[(int'(fc_q) + k_cnt)*ITEM_WIDTH +: ITEM_WIDTH] =
                  s_axis_tdata[i*ITEM_WIDTH +: ITEM_WIDTH];
            end
            k_cnt = k_cnt + 1;
         end
      end
      total = int'(fc_q) + k_cnt;
   end

   always_comb begin
      accept       = s_axis_tvalid && s_axis_tready;
      emit_full    = accept && (total == ITEM_COUNT);
      emit_partial = accept && s_axis_tlast && (total > 0) && (total < ITEM_COUNT);
      emit_empty   = accept && s_axis_tlast && (total == 0) && pe_q;
      drop_empty   = accept && s_axis_tlast && (total == 0) && !pe_q;

      phase_d     = phase_q;
      sel_d       = sel_q;
      sop_d       = sop_q;
      pe_d        = pe_q;
      fc_d        = fc_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (out_valid_q && m_axis_tready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         sel_d   = cur_sel;
         sop_d   = s_axis_tlast;
         phase_d = s_axis_tlast ? '0 :
                   CHANNEL_COUNT_BITS'((int'(cur_phase) + ITEM_COUNT) % CHANNEL_COUNT);

         // The accumulator restarts empty after any emission and at packet end,
         // so unused lanes of a partial word are always zero.
         if (emit_full || emit_partial || s_axis_tlast) begin
            fc_d  = '0;
            acc_d = '0;
         end else begin
            fc_d  = FC_BITS'(total);
            acc_d = acc_new;
         end

         // pe records that a full word went out without tlast, so the packet
         // still owes its consumer a terminating beat.
         if (s_axis_tlast) begin
            pe_d = 1'b0;
         end else if (emit_full) begin
            pe_d = 1'b1;
         end

         if (emit_full || emit_partial) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_new;
            out_last_d  = s_axis_tlast;
            for (int b = 0; b < KEEP_WIDTH; b++) begin
               out_keep_d[b] = (b < total * ITEM_BYTES);
            end
         end else if (emit_empty) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_keep_d  = '0;
            out_last_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         phase_q     <= '0;
         sel_q       <= '0;
         sop_q       <= 1'b1;
         pe_q        <= 1'b0;
         fc_q        <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         sel_q       <= sel_d;
         sop_q       <= sop_d;
         pe_q        <= pe_d;
         fc_q        <= fc_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

`ifdef AXIS_CHANNEL_EXTRACT_STATS_EN
   logic [31:0] stat_items_q, stat_items_d;
   logic [15:0] stat_empty_q, stat_empty_d;

   always_comb begin
      stat_items_d = stat_items_q;
      stat_empty_d = stat_empty_q;
      if (emit_full || emit_partial) begin
         stat_items_d = stat_items_q + 32'(total);
      end
      if (drop_empty && (stat_empty_q != 16'hFFFF)) begin
         stat_empty_d = stat_empty_q + 16'd1;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         stat_items_q <= '0;
         stat_empty_q <= '0;
      end else begin
         stat_items_q <= stat_items_d;
         stat_empty_q <= stat_empty_d;
      end
   end

   assign stat_item_count      = stat_items_q;
   assign stat_empty_pkt_count = stat_empty_q;
`endif

endmodule

// File: doc/axis_channel_extract_packer.md
Name: axis_channel_extract_packer

Overview:
- AXI4-Stream block that takes a pixel-interleaved stream (items ordered ch0, ch1, …, chC-1, ch0, …) and outputs only the items of one runtime-selected channel.
- The selected items are packed densely into full-width output words.
- It tracks the channel phase across beats itself, so ITEM_COUNT does not have to be a multiple of CHANNEL_COUNT.
- It sits between the bitmap ingress stream and the per-channel tensor reshape stages.

Parameters:
- TDATA_WIDTH, 256, stream data width in bits. Must be a multiple of ITEM_WIDTH.
- ITEM_WIDTH, 8, width of one item in bits. Must be a multiple of 8.
- CHANNEL_COUNT, 3, number of interleaved channels. Must be at least 2.
- ITEM_COUNT, TDATA_WIDTH/ITEM_WIDTH, local: items per beat (N).
- CHANNEL_COUNT_BITS, $clog2(CHANNEL_COUNT), local: width of the channel index.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- channel_select  in  CHANNEL_COUNT_BITS  channel to extract; sampled on the first beat of each packet.
- s_axis_tdata  in  TDATA_WIDTH  interleaved input data; item 0 is in the LSBs.
- s_axis_tkeep  in  TDATA_WIDTH/8  byte enables; only honoured on the tlast beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  TDATA_WIDTH  packed single-channel data.
- m_axis_tkeep  out  TDATA_WIDTH/8  valid output bytes, contiguous from the LSB.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  end of packet.

Behaviour:
- Reset (axis_resetn low, asynchronous):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - phase=0, fill count fc=0, sop=1, packet-emitted flag pe=0.
  - s_axis_tready is combinational and equals 0 while in reset.
- Reset asserted mid-packet: discard the partial packet and clear the accumulator. The next accepted beat is treated as start of packet.
- s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - An accepted beat is s_axis_tvalid && s_axis_tready.
- Output handshake: the output register holds its value while m_axis_tvalid && !m_axis_tready. Data, keep and last are stable under backpressure.
- Start of packet (sop=1):
  - Latch channel_select into sel.
  - Use phase=0 for this beat.
  - Clear sop.
- Phase: the channel of item 0 of the current beat.
  - After each accepted non-last beat: phase <= (phase + ITEM_COUNT) mod CHANNEL_COUNT.
  - After an accepted tlast beat: phase <= 0, sop <= 1.
- Item selection: item i of a beat is selected when (phase + i) mod CHANNEL_COUNT == sel.
  - On the tlast beat, item i also needs all of its keep bytes set. Keep is low-contiguous.
  - On non-last beats, tkeep is ignored.
  - The number of items selected from one beat, k, is at most ceil(N/C).
- Packing: selected items are appended in ascending i order at accumulator positions fc, fc+1, ….
  - Invariant: fc + k <= N. Per-packet totals after b beats never exceed ceil(bN/C), and C beats yield exactly N. The accumulator is therefore N items and never overflows.
- Emit on an accepted beat when either condition holds:
  - fc + k == N: load the output register with the full accumulator, tkeep all ones, tlast = s_axis_tlast. Set fc <= 0 and pe <= 1.
  - s_axis_tlast and 0 < fc + k < N: load the output register with tkeep covering (fc+k)*ITEM_WIDTH/8 low bytes, tlast=1. Set fc <= 0.
- Edge cases at tlast when fc + k == 0:
  - If pe=1, emit one beat with tdata=0, tkeep=0, tlast=1.
  - If pe=0, the packet produced nothing and no output beat is emitted.
  - Clear pe in both cases.
- Latency: the output beat is valid the cycle after the input beat that completes it is accepted.
- A latched sel >= CHANNEL_COUNT selects nothing, so the whole packet is dropped silently.
- A channel_select change mid-packet has no effect until the next start of packet.

Optional Feature:
- Macro: AXIS_CHANNEL_EXTRACT_STATS_EN.
- When defined, add two outputs:
  - stat_item_count [31:0]: total selected items emitted. Wraps modulo 2^32.
  - stat_empty_pkt_count [15:0]: packets dropped with zero selected items. Saturates at 0xFFFF.
  - Both counters reset to 0 and update in the cycle the corresponding emission or drop decision is taken.
- When undefined: no such ports and no counter logic.

Test Plan:
1. N=32, C=3, sel=0, 3-beat packet with bytes 0..95 and tlast on beat 3 → one output beat, tdata bytes = 0,3,…,93, tkeep=0xFFFFFFFF, tlast=1.
2. Same stimulus with sel=1 → one beat containing 1,4,…,94. With sel=2 → one beat containing 2,5,…,95.
3. Single beat with tlast, tkeep all ones, sel=2 → one beat holding 10 items (2,5,…,29), tkeep=0x000003FF, tlast=1.
4. 4-beat packet with sel=0 → beat 1: 32 items, tlast=0; beat 2: items 96,99,…,126 (11 items), tkeep=0x7FF, tlast=1.
5. Backpressure: m_axis_tready low for 5 cycles during test 1 → s_axis_tready low while the output is held; output data is stable; no item lost or duplicated.
6. Reset pulsed after beat 2 of test 1, then a fresh test-1 packet → exactly one output beat, identical to test 1. Separately, sel=3 on a 1-beat packet → no output, and stat_empty_pkt_count=1 when the stats macro is enabled.
